result_store: RTL
=================

// Module: result_store
// PURPOSE
//  Write-side counterpart of the operand ROM. Captures each finished result pair
//  (quotient/product + remainder, 16 b each) from the arithmetic datapath on a done strobe.
//  Serialises each pair into four bytes in an internal 8-bit result RAM.
//  A testbench or host reads results back through a registered read port.
//  Sits after regC/RegResto in the system top.
// PARAMETERS
//  DATA_W   8    RAM word width (matches operand ROM data width)
//  ADDR_W   9    RAM address width; depth = 2**ADDR_W bytes
//  REC_B    4    bytes per record (fixed: QH, QL, RH, RL)
// PORTS
//  clk        in   1       system clock; all logic on rising edge
//  reset      in   1       synchronous, active-high
//  valid      in   1       1-cycle strobe: result/rest are final this cycle
//  result     in   16      quotient or product (regC output)
//  rest       in   16      remainder (RegResto output); 0 for multiply
//  busy       out  1       record serialisation in progress
//  full       out  1       RAM holds 2**ADDR_W/REC_B records
//  lost       out  1       sticky: a valid was dropped (busy or full)
//  count      out  ADDR_W-1  records completely written (0..128)
//  rd_en      in   1       read request
//  rd_addr    in   ADDR_W  byte address to read
//  rd_data    out  DATA_W  read data, valid 1 cycle after rd_en
// BEHAVIOUR
//  - Reset values: busy=0, full=0, lost=0, count=0, rd_data=0; internal wr_addr=0, FSM=IDLE.
//    Reset does not clear RAM contents.
//  - FSM: IDLE -> W_QH -> W_QL -> W_RH -> W_RL -> IDLE.
//  - IDLE: on valid && !full, latch result/rest into holding regs and go to W_QH. busy=1 from the next cycle.
//  - W_QH/W_QL/W_RH/W_RL each write one byte at wr_addr, then increment wr_addr.
//    Byte order: result[15:8], result[7:0], rest[15:8], rest[7:0]. Record n starts at byte 4n (big-endian).
//  - Leaving W_RL: count+1; busy=0 in IDLE. valid to busy-low = 5 cycles; next record accepted the cycle busy=0.
//  - valid while busy, or while full: input ignored, lost<=1 (sticky until reset). Held record is unaffected.
//  - full=1 when count==128 (wr_addr wrapped to 0). No wrap-overwrite: full blocks all further writes until reset.
//  - Read: if rd_en, rd_data <= ram[rd_addr] next cycle; otherwise rd_data holds its value.
//    Reads are legal at any time, including while busy.
//  - Read/write same address same cycle: rd_data returns the OLD byte (read-before-write).
//  - Reset asserted mid-record: FSM to IDLE, partial record abandoned, count excludes it.
//    Partially written bytes stay in RAM but are overwritten by the next record.
//  - valid coincident with reset: ignored.
//  - count/full/lost update only at clock edges; no combinational input->output paths.
// STRUCTURE
//  - Shared include sistema_defs.vh: DATA_W, ADDR_W, REC_B, byte offsets OFS_QH=0, OFS_QL=1, OFS_RH=2, OFS_RL=3.
//    FSM state encodings (3 b) defined locally via localparam.
//  - Sub-module result_ram: single-clock simple dual-port RAM, 2**ADDR_W x DATA_W.
//    One write port (we, waddr, wdata) and one registered read port (re, raddr, rdata).
//    Read-before-write semantics.
//  - result_store: FSM, holding regs, wr_addr/count counters, status flags.
// TESTING
//  - Reset, then valid with result=16'h1234, rest=16'h0005.
//    -> busy for 4 cycles; bytes 0..3 read back 12,34,00,05; count=1; lost=0.
//  - Two back-to-back records: second valid issued the cycle busy drops (result=16'h00FF, rest=0).
//    -> bytes 4..7 = 00,FF,00,00; count=2.
//  - Second valid 2 cycles after the first (during busy).
//    -> lost=1; count=1; bytes 4..7 unchanged from pre-test values.
//  - Write 128 records (result=n, rest=~n).
//    -> full=1 after the last; 129th valid sets lost, byte 0 still = 00 (record 0 intact).
//  - rd_en at addr 2 on the same cycle W_RH writes addr 2 (old value AA, new 00).
//    -> rd_data=AA next cycle; reread gives 00.
//  - Reset during W_RH of the first record, then new record 16'hBEEF/16'h0001.
//    -> count=1, bytes 0..3 = BE,EF,00,01; busy=0 during reset.

Source files
------------

// File: rtl/result_store_pkg.sv
// Shared widths, byte offsets, FSM encoding and the byte-select helper for the
// result store and its RAM.
package result_store_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 9;
  localparam int REC_B   = 4;
  localparam int CNT_W   = ADDR_W - 1;
  localparam int MAX_REC = (1 << ADDR_W) / REC_B;

  localparam logic [1:0] OFS_QH = 2'd0;
  localparam logic [1:0] OFS_QL = 2'd1;
  localparam logic [1:0] OFS_RH = 2'd2;
  localparam logic [1:0] OFS_RL = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W_QH = 3'd1,
    W_QL = 3'd2,
    W_RH = 3'd3,
    W_RL = 3'd4
  } state_t;

  // Big-endian serialisation: result high, result low, rest high, rest low.
  function automatic logic [DATA_W-1:0] selectByte(input logic [15:0] res,
                                                   input logic [15:0] rem,
                                                   input logic [1:0]  ofs);
    case (ofs)
      OFS_QH:  return res[15:8];
      OFS_QL:  return res[7:0];
      OFS_RH:  return rem[15:8];
      OFS_RL:  return rem[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/result_store_if.sv
// Capture and read-back bus of the result store. The master side is the
// datapath/host, the slave side is the store itself.
interface result_store_if;
  import result_store_pkg::*;

  logic              valid;
  logic [15:0]       result;
  logic [15:0]       rest;
  logic              busy;
  logic              full;
  logic              lost;
  logic [CNT_W-1:0]  count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output valid, result, rest, rd_en, rd_addr,
    input  busy, full, lost, count, rd_data
  );

  modport slave (
    input  valid, result, rest, rd_en, rd_addr,
    output busy, full, lost, count, rd_data
  );

endinterface

// File: rtl/result_store_ram.sv
// Single-clock simple dual-port byte RAM with a registered read port;
// a read of the address being written returns the old byte.
module result_store_ram
  import result_store_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [0:(1 << ADDR_W)-1];

  // Write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port, holds its value when not reading
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 8'h00;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/result_store.sv
// Captures result/rest pairs on a valid strobe and serialises each pair as a
// four-byte big-endian record into the result RAM.
module result_store
  import result_store_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  result_store_if.slave bus
);

  state_t            state_r, nextState_s;
  logic [15:0]       holdResult_r, holdRest_r;
  logic [ADDR_W-1:0] wrAddr_r;
  logic [CNT_W-1:0]  count_r;
  logic              busy_r, full_r, lost_r;
  logic              we_s, accept_s, drop_s, recDone_s;
  logic [1:0]        ofs_s;
  logic [DATA_W-1:0] rdData_s;

  // Next-state and write-port decode
  always_comb begin
    nextState_s = state_r;
    we_s        = 1'b0;
    ofs_s       = OFS_QH;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.valid && !full_r) begin
          accept_s    = 1'b1;
          nextState_s = W_QH;
        end else begin
          nextState_s = IDLE;
        end
      end
      W_QH: begin we_s = 1'b1; ofs_s = OFS_QH; nextState_s = W_QL; end
      W_QL: begin we_s = 1'b1; ofs_s = OFS_QL; nextState_s = W_RH; end
      W_RH: begin we_s = 1'b1; ofs_s = OFS_RH; nextState_s = W_RL; end
      W_RL: begin we_s = 1'b1; ofs_s = OFS_RL; nextState_s = IDLE; end
      default: nextState_s = IDLE;
    endcase
  end

  // A strobe is dropped whenever it cannot start a record.
  assign drop_s    = bus.valid && ((state_r != IDLE) || full_r);
  assign recDone_s = (state_r == W_RL);

  // State, holding registers, address/record counters and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      holdResult_r <= 16'h0000;
      holdRest_r   <= 16'h0000;
      wrAddr_r     <= '0;
      count_r      <= '0;
      busy_r       <= 1'b0;
      full_r       <= 1'b0;
      lost_r       <= 1'b0;
    end else begin
      state_r <= nextState_s;
      busy_r  <= (nextState_s != IDLE);
      if (accept_s) begin
        holdResult_r <= bus.result;
        holdRest_r   <= bus.rest;
      end
      if (we_s) begin
        wrAddr_r <= wrAddr_r + ADDR_W'(1);
      end
      if (recDone_s) begin
        count_r <= count_r + CNT_W'(1);
        full_r  <= (count_r == CNT_W'(MAX_REC - 1));
      end
      if (drop_s) begin
        lost_r <= 1'b1;
      end
    end
  end

  result_store_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .waddr (wrAddr_r),
    .wdata (selectByte(holdResult_r, holdRest_r, ofs_s)),
    .re    (bus.rd_en),
    .raddr (bus.rd_addr),
    .rdata (rdData_s)
  );

  assign bus.busy    = busy_r;
  assign bus.full    = full_r;
  assign bus.lost    = lost_r;
  assign bus.count   = count_r;
  assign bus.rd_data = rdData_s;

endmodule
